s2p_sched: RTL and testbench

S2P_SCHED -- requirements
Module: s2p_sched

---
 rtl/s2p_sched_pkg.sv | 20 ++
 rtl/s2p_sched_rr_arb.sv | 70 +++++++
 rtl/s2p_sched.sv | 173 +++++++++++++++++
 tb/tb_s2p_sched.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/s2p_sched_pkg.sv
// Shared definitions for the serial-to-parallel scheduler: FSM encoding and
// a constant-evaluable ceiling-log2 helper used for index and counter widths.
package s2p_sched_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Never returns less than 1 so a 2-entry index still has a real bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((32'sd1 <<< result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/s2p_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves
// past the winner when update_i is asserted.
module rr_arb
    import s2p_sched_pkg::*;
#(
    parameter int  N  = 4,
    localparam int IW = clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    input  logic          update_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_id_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW:0]   sum_s;
    logic [IW-1:0] idx_s;
    logic          found_s;

    // Priority search starting at ptr_q, wrapping modulo N.
    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        found_s    = 1'b0;
        sum_s      = '0;
        idx_s      = '0;
        for (int k = 0; k < N; k++) begin
            sum_s = {1'b0, ptr_q} + (IW + 1)'(k);
            if (sum_s >= (IW + 1)'(N)) begin
                sum_s = sum_s - (IW + 1)'(N);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[IW-1:0];
            if (!found_s && req_i[idx_s]) begin
                grant_o[idx_s] = 1'b1;
                grant_id_o     = idx_s;
                found_s        = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer advance to the requester after the winner.
    always_comb begin
        if (update_i && found_s) begin
            if (grant_id_o == IW'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_id_o + IW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register; requester 0 leads after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/s2p_sched.sv
// Serial-to-parallel scheduler: arbitrates N beat streams, packs P beats of the
// granted requester into one word and presents it with its source id.
module s2p_sched
    import s2p_sched_pkg::*;
#(
    parameter int  N       = 4,
    parameter int  P       = 2,
    parameter int  DATA_IN = 8,
    localparam int IW      = clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [N-1:0]         req_valid,
    input  logic [N*DATA_IN-1:0] req_data,
    output logic [N-1:0]         req_ready,
    output logic [P*DATA_IN-1:0] out_data,
    output logic [IW-1:0]        out_id,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int CW = clog2(P);
    localparam int PW = P * DATA_IN;
    localparam int HW = (P - 1) * DATA_IN;

    state_e        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] pack_q, pack_d;
    logic [PW-1:0] out_data_q, out_data_d;
    logic [IW-1:0] out_id_q, out_id_d;
    logic          out_valid_q, out_valid_d;

    logic [N-1:0]       arb_grant_s;
    logic [IW-1:0]      arb_id_s;
    logic               arb_update_s;
    logic [DATA_IN-1:0] beat_s;
    logic [PW-1:0]      word_s;
    logic               last_s;
    logic               accept_s;

    rr_arb #(.N(N)) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_valid),
        .update_i   (arb_update_s),
        .grant_o    (arb_grant_s),
        .grant_id_o (arb_id_s)
    );

    // Beat of the granted requester and the word it would complete.
    always_comb begin
        beat_s = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                beat_s = req_data[i*DATA_IN +: DATA_IN];
            end else begin
                beat_s = beat_s;
            end
        end
        word_s   = {pack_q, beat_s};
        last_s   = (cnt_q == CW'(P - 1));
        accept_s = |(req_valid & req_ready);
    end

    // Output process: the closing beat waits for a free or draining slot.
    always_comb begin
        req_ready = '0;
        case (state_q)
            ST_IDLE: req_ready = '0;
            ST_BURST: begin
                if (!flush && (!last_s || !out_valid_q || out_ready)) begin
                    req_ready = grant_q;
                end else begin
                    req_ready = '0;
                end
            end
            default: req_ready = '0;
        endcase
    end

    // Next-state process; flush wins over both arbitration and acceptance.
    always_comb begin
        state_d      = state_q;
        arb_update_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!flush && (|req_valid)) begin
                    state_d      = ST_BURST;
                    arb_update_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (flush || (accept_s && last_s)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BURST;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: grant capture, packing and output slot.
    always_comb begin
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        cnt_d      = cnt_q;
        pack_d     = pack_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        if (arb_update_s) begin
            grant_d    = arb_grant_s;
            grant_id_d = arb_id_s;
        end else begin
            grant_d = grant_q;
        end
        if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (flush) begin
            cnt_d  = '0;
            pack_d = '0;
        end else if (accept_s && last_s) begin
            cnt_d       = '0;
            pack_d      = '0;
            out_data_d  = word_s;
            out_id_d    = grant_id_q;
            out_valid_d = 1'b1;
        end else if (accept_s) begin
            cnt_d  = cnt_q + CW'(1);
            pack_d = word_s[HW-1:0];
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            grant_id_q  <= '0;
            cnt_q       <= '0;
            pack_q      <= '0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            cnt_q       <= cnt_d;
            pack_q      <= pack_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ST_BURST);

endmodule

// File: tb/tb_s2p_sched.sv
// Directed bench for s2p_sched (N=4, P=2, DATA_IN=8): inputs change just after
// the falling edge, outputs are checked 1 ns later.
module tb_s2p_sched;

    localparam int N  = 4;
    localparam int P  = 2;
    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [15:0] out_data;
    logic [1:0]  out_id;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0]  oh;
    logic [7:0]  d;

    always #5 clk = ~clk;

    s2p_sched #(.N(N), .P(P), .DATA_IN(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input int i, input logic [7:0] v);
        req_data[i*8 +: 8] = v;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 4'b0000; req_data = 32'h0; out_ready = 1'b1;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'd0);
        check("rst_ready", {28'd0, req_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Single requester 2: 0xAA then 0xBB
        @(negedge clk); rst = 1'b0; req_valid = 4'b0100; set_beat(2, 8'hAA); #1;
        check("s_idle_ready", {28'd0, req_ready}, 32'h0);
        check("s_idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); #1;
        check("s_b0_busy", {31'd0, busy}, 32'd1);
        check("s_b0_ready", {28'd0, req_ready}, 32'h4);
        @(negedge clk); set_beat(2, 8'hBB); #1;
        check("s_b1_ready", {28'd0, req_ready}, 32'h4);
        check("s_b1_nov", {31'd0, out_valid}, 32'd0);
        @(negedge clk); req_valid = 4'b0000; #1;
        check("s_out_valid", {31'd0, out_valid}, 32'd1);
        check("s_out_data", {16'd0, out_data}, 32'hAABB);
        check("s_out_id", {30'd0, out_id}, 32'd2);
        check("s_out_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); #1;
        check("s_out_drop", {31'd0, out_valid}, 32'd0);

        // All four continuously valid after a fresh reset
        @(negedge clk); rst = 1'b1; #1; rst = 1'b0;
        req_valid = 4'b1111;
        set_beat(0, 8'h10); set_beat(1, 8'h20); set_beat(2, 8'h30); set_beat(3, 8'h40); #1;
        check("rr_c0_ready", {28'd0, req_ready}, 32'h0);
        check("rr_c0_nov", {31'd0, out_valid}, 32'd0);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 15) req_valid = 4'b0000;
            #1;
            if (k % 3 == 0) begin
                d = 8'((order[k/3-1] + 1) * 16);
                check("rr_valid", {31'd0, out_valid}, 32'd1);
                check("rr_id", {30'd0, out_id}, 32'(order[k/3-1]));
                check("rr_data", {16'd0, out_data}, {16'd0, d, d});
                check("rr_idle_ready", {28'd0, req_ready}, 32'h0);
            end else begin
                oh = 4'b0001 << order[k/3];
                check("rr_nov", {31'd0, out_valid}, 32'd0);
                check("rr_grant", {28'd0, req_ready}, {28'd0, oh});
            end
        end

        // Backpressure on the closing beat of a second burst from req 1
        @(negedge clk); out_ready = 1'b0; req_valid = 4'b0010; set_beat(1, 8'h01); #1;
        @(negedge clk); #1;
        check("bp_b0_ready", {28'd0, req_ready}, 32'h2);
        @(negedge clk); set_beat(1, 8'h02); #1;
        check("bp_b1_ready", {28'd0, req_ready}, 32'h2);
        @(negedge clk); set_beat(1, 8'h03); #1;
        check("bp_w1_valid", {31'd0, out_valid}, 32'd1);
        check("bp_w1_data", {16'd0, out_data}, 32'h0102);
        check("bp_w1_id", {30'd0, out_id}, 32'd1);
        @(negedge clk); #1;
        check("bp_b2_ready", {28'd0, req_ready}, 32'h2);
        check("bp_hold0", {16'd0, out_data}, 32'h0102);
        @(negedge clk); set_beat(1, 8'h04); #1;
        check("bp_last_blocked", {28'd0, req_ready}, 32'h0);
        check("bp_busy", {31'd0, busy}, 32'd1);
        check("bp_hold1", {16'd0, out_data}, 32'h0102);
        @(negedge clk); #1;
        check("bp_last_blocked2", {28'd0, req_ready}, 32'h0);
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check("bp_hold2", {16'd0, out_data}, 32'h0102);
        @(negedge clk); out_ready = 1'b1; #1;
        check("bp_release_ready", {28'd0, req_ready}, 32'h2);
        @(negedge clk); req_valid = 4'b0000; #1;
        check("bp_w2_valid", {31'd0, out_valid}, 32'd1);
        check("bp_w2_data", {16'd0, out_data}, 32'h0304);
        check("bp_w2_id", {30'd0, out_id}, 32'd1);
        @(negedge clk); #1;
        check("bp_w2_drop", {31'd0, out_valid}, 32'd0);

        // Flush after the first beat from req 3
        @(negedge clk); req_valid = 4'b1000; set_beat(3, 8'h11); #1;
        @(negedge clk); #1;
        check("fl_b0_ready", {28'd0, req_ready}, 32'h8);
        @(negedge clk); flush = 1'b1; set_beat(3, 8'h99); #1;
        check("fl_ready_low", {28'd0, req_ready}, 32'h0);
        @(negedge clk); flush = 1'b0; set_beat(3, 8'h22); #1;
        check("fl_idle", {31'd0, busy}, 32'd0);
        check("fl_no_word", {31'd0, out_valid}, 32'd0);
        @(negedge clk); #1;
        check("fl_b0b_ready", {28'd0, req_ready}, 32'h8);
        @(negedge clk); set_beat(3, 8'h33); #1;
        check("fl_b1b_ready", {28'd0, req_ready}, 32'h8);
        @(negedge clk); req_valid = 4'b0000; #1;
        check("fl_valid", {31'd0, out_valid}, 32'd1);
        check("fl_data", {16'd0, out_data}, 32'h2233);
        check("fl_id", {30'd0, out_id}, 32'd3);

        // Async reset mid-burst with a pending word held
        @(negedge clk); out_ready = 1'b0; req_valid = 4'b0001; set_beat(0, 8'h55); #1;
        @(negedge clk); #1;
        check("ar_b0_ready", {28'd0, req_ready}, 32'h1);
        @(negedge clk); set_beat(0, 8'h66); #1;
        @(negedge clk); set_beat(0, 8'h77); #1;
        check("ar_w_valid", {31'd0, out_valid}, 32'd1);
        check("ar_w_data", {16'd0, out_data}, 32'h5566);
        @(negedge clk); #1;
        check("ar_b0b_ready", {28'd0, req_ready}, 32'h1);
        @(negedge clk); #1;
        check("ar_mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1; #1;
        check("ar_valid0", {31'd0, out_valid}, 32'd0);
        check("ar_data0", {16'd0, out_data}, 32'h0);
        check("ar_id0", {30'd0, out_id}, 32'd0);
        check("ar_ready0", {28'd0, req_ready}, 32'h0);
        check("ar_busy0", {31'd0, busy}, 32'd0);
        @(negedge clk); rst = 1'b0; out_ready = 1'b1; req_valid = 4'b0011;
        set_beat(0, 8'hA0); set_beat(1, 8'hB1); #1;
        check("ar_post_ready", {28'd0, req_ready}, 32'h0);
        check("ar_post_nov", {31'd0, out_valid}, 32'd0);
        @(negedge clk); #1;
        check("ar_prio0", {28'd0, req_ready}, 32'h1);
        @(negedge clk); #1;
        check("ar_prio0_b1", {28'd0, req_ready}, 32'h1);
        @(negedge clk); req_valid = 4'b0000; #1;
        check("ar_word_valid", {31'd0, out_valid}, 32'd1);
        check("ar_word_data", {16'd0, out_data}, 32'hA0A0);
        check("ar_word_id", {30'd0, out_id}, 32'd0);

        // Granted requester 2 stalls for 5 cycles while others request
        @(negedge clk); req_valid = 4'b0100; set_beat(2, 8'hC1); #1;
        @(negedge clk); #1;
        check("st_b0_ready", {28'd0, req_ready}, 32'h4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); req_valid = 4'b1010; set_beat(2, 8'hEE); set_beat(1, 8'hDD); set_beat(3, 8'hDD); #1;
            check("st_busy", {31'd0, busy}, 32'd1);
            check("st_grant_kept", {28'd0, req_ready}, 32'h4);
            check("st_nov", {31'd0, out_valid}, 32'd0);
        end
        @(negedge clk); req_valid = 4'b0100; set_beat(2, 8'hC2); #1;
        check("st_b1_ready", {28'd0, req_ready}, 32'h4);
        @(negedge clk); req_valid = 4'b0000; #1;
        check("st_valid", {31'd0, out_valid}, 32'd1);
        check("st_data", {16'd0, out_data}, 32'hC1C2);
        check("st_id", {30'd0, out_id}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
